rr_req_queue: RTL and testbench
===============================

Name: rr_req_queue

Overview:
- Request front-end that sits directly upstream of the 4-client round-robin arbiter.
- Holds a small FIFO per client. Drives the arbiter's REQ vector from FIFO non-empty status.
- Consumes the arbiter's one-hot GNT and forwards the granted client's head entry to a single shared output port with a valid/ready handshake.

Parameters:
- DW, 8, data width per entry
- DEPTH, 4, entries per client FIFO; power of 2, minimum 2
- NCLI, 4, client count; fixed at 4 to match the arbiter's REQ/GNT width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- in_valid  in  4  per-client push strobe
- in_ready  out  4  per-client not-full
- in_data  in  4*DW  per-client push data; client i occupies bits [i*DW +: DW]
- REQ  out  4  to arbiter; REQ[i] = FIFO i non-empty
- GNT  in  4  from arbiter; expected one-hot or zero
- out_valid  out  1  shared output holds a valid entry
- out_ready  in  1  downstream accept
- out_data  out  DW  forwarded entry
- out_id  out  2  client index of out_data

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-low.
- Reset (rst=0):
  - All FIFOs empty, pointers and counts 0.
  - REQ=0, in_ready=4'b1111, out_valid=0, out_data=0, out_id=0.
  - Reset takes effect immediately, including mid-transfer. Queued entries are discarded.
- Push rules:
  - Client i push occurs when in_valid[i] & in_ready[i].
  - in_ready[i] = !full_i, where full_i means count_i == DEPTH.
  - No push-while-full, even if the same cycle pops. Pushes to all 4 clients may occur in the same cycle.
- REQ rules:
  - REQ[i] = (count_i != 0), driven combinationally from the registered count.
  - A push into an empty FIFO raises REQ[i] on the following cycle.
- Output slot:
  - slot_free = !out_valid | out_ready.
- Pop and forward, on an edge where slot_free is true and GNT is one-hot with GNT[i]=1 and count_i != 0:
  - The FIFO i head loads into out_data, out_id=i, out_valid=1.
  - FIFO i pops and count_i decrements.
  - Latency from grant to data: 1 cycle.
- Stall rules:
  - Grant while the slot is stalled (out_valid & !out_ready): nothing pops, and the FIFO is unchanged.
  - The arbiter re-grants later. REQ stays asserted because the queue remains non-empty.
- Drain rule:
  - If out_ready=1 and no qualifying grant, out_valid falls to 0 next cycle.
  - out_data and out_id hold their last values.
- Ignored grants:
  - GNT=0, non-one-hot GNT, or GNT to an empty FIFO: no pop, no output load.
- Same-FIFO push and pop in one cycle (not full): count unchanged, and both operations take effect.
- Last-entry pop: when the pop takes the last entry with no simultaneous push, REQ[i] deasserts the next cycle.
- Pointers:
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - Count is log2(DEPTH)+1 bits.
- Ordering: FIFO order is strictly preserved per client. Cross-client order is determined by the arbiter.

Optional Feature:
- Macro: RRQ_ERR_CHECK_EN
- Defined: adds output port gnt_err (1 bit), reset 0. It sets sticky on any edge where either condition holds:
  - GNT has more than one bit set;
  - GNT[i]=1 while count_i==0 and no push into FIFO i occurred on the previous cycle.
- gnt_err clears only on reset.
- Not defined: the port is absent. Illegal grants are silently ignored as described above.

Decomposition:
- Shared package rr_arb_pkg:
  - NCLI=4, CLI_IDW=2
  - typedef cli_vec_t as a 4-bit vector
  - helper function onehot_idx (one-hot to 2-bit index, plus a valid flag)
- The arbiter reuses the same package.
- Sub-module rrq_fifo: synchronous FIFO with DW and DEPTH parameters. Ports push, pop, din, dout, count, full, empty. Instantiated 4x.
- Top level handles grant decode, the output register, and REQ generation.

Test Plan:
- Reset: hold rst=0 with in_valid=4'b1111 -> REQ=0, out_valid=0, in_ready=4'b1111. After release, one push per client -> REQ=4'b1111 one cycle later.
- Single client: push 0x11, 0x22, 0x33 to client 3; drive GNT=4'b1000 for 3 cycles with out_ready=1 -> out_data 0x11, 0x22, 0x33 in order, out_id=3. REQ[3] falls after the third pop.
- Full: push 5 entries to client 1 (DEPTH=4) -> in_ready[1]=0 after the 4th; the 5th is not accepted. One pop -> in_ready[1]=1 next cycle.
- Backpressure: out_ready=0 with GNT=4'b0010 held 3 cycles -> out_valid=1, out_data stable at the first entry, count_1 unchanged. Raise out_ready -> the next entry loads the following cycle.
- Mixed with the arbiter instantiated: REQ pattern 4'b1111 with 1 entry each -> outputs 4 entries, one per grant, out_id matching each GNT bit. No duplicates, no losses.
- With RRQ_ERR_CHECK_EN defined: force GNT=4'b0110 -> no pop, gnt_err=1 and sticky until rst=0.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 4-client round-robin arbiter and its request front-end.
// Holds the client count, index width, request/grant vector type and one-hot decode.
package rr_arb_pkg;

    localparam int NCLI    = 4;
    localparam int CLI_IDW = 2;

    typedef logic [NCLI-1:0] cli_vec_t;

    typedef struct packed {
        logic               valid;
        logic [CLI_IDW-1:0] idx;
    } onehot_t;

    // valid is low for an all-zero or multi-hot vector; idx is 0 in that case.
    function automatic onehot_t onehot_idx(input cli_vec_t vec);
        onehot_t r;
        r.valid = 1'b1;
        r.idx   = '0;
        case (vec)
            4'b0001: r.idx = 2'd0;
            4'b0010: r.idx = 2'd1;
            4'b0100: r.idx = 2'd2;
            4'b1000: r.idx = 2'd3;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rrq_fifo.sv
// Per-client synchronous FIFO for rr_req_queue; head entry is visible on dout.
// Push while full and pop while empty are ignored.
module rrq_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DW-1:0]          din,
    output logic [DW-1:0]          dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == DEPTH[AW:0]);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Pointers are exactly log2(DEPTH) bits so they wrap without compare logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/rr_req_queue.sv
// Request front-end for the 4-client round-robin arbiter: per-client FIFOs drive REQ,
// the one-hot GNT pops the granted head into a shared output register.
// Optional macro RRQ_ERR_CHECK_EN adds a sticky gnt_err output for illegal grants.
module rr_req_queue
    import rr_arb_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCLI-1:0]    in_valid,
    output logic [NCLI-1:0]    in_ready,
    input  logic [NCLI*DW-1:0] in_data,
    output logic [NCLI-1:0]    REQ,
    input  logic [NCLI-1:0]    GNT,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [CLI_IDW-1:0] out_id
`ifdef RRQ_ERR_CHECK_EN
    ,
    output logic               gnt_err
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [DW-1:0]      w_dout  [NCLI];
    logic [CW-1:0]      w_count [NCLI];
    cli_vec_t           w_full;
    cli_vec_t           w_empty;
    cli_vec_t           w_push;
    cli_vec_t           w_pop;
    onehot_t            w_gnt;
    logic               w_slot_free;
    logic               w_pop_any;

    logic               r_out_valid;
    logic [DW-1:0]      r_out_data;
    logic [CLI_IDW-1:0] r_out_id;

    for (genvar g = 0; g < NCLI; g++) begin : g_fifo
        rrq_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (w_push[g]),
            .pop   (w_pop[g]),
            .din   (in_data[g*DW +: DW]),
            .dout  (w_dout[g]),
            .count (w_count[g]),
            .full  (w_full[g]),
            .empty (w_empty[g])
        );
    end

    assign in_ready = ~w_full;
    assign w_push   = in_valid & ~w_full;

    always_comb begin
        REQ = '0;
        for (int i = 0; i < NCLI; i++) REQ[i] = (w_count[i] != '0);
    end

    // A grant only pops when the output slot can take the entry this edge.
    assign w_gnt       = onehot_idx(GNT);
    assign w_slot_free = ~r_out_valid | out_ready;
    assign w_pop_any   = w_slot_free & w_gnt.valid & ~w_empty[w_gnt.idx];

    always_comb begin
        w_pop = '0;
        if (w_pop_any) w_pop[w_gnt.idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
        end else if (w_pop_any) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_dout[w_gnt.idx];
            r_out_id    <= w_gnt.idx;
        end else if (w_slot_free) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;

`ifdef RRQ_ERR_CHECK_EN
    cli_vec_t r_prev_push;
    logic     r_gnt_err;
    logic     w_gnt_bad;

    // A grant to a FIFO filled on the previous edge is tolerated: the arbiter saw REQ late.
    assign w_gnt_bad = ((|GNT) & ~w_gnt.valid) | (|(GNT & w_empty & ~r_prev_push));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev_push <= '0;
            r_gnt_err   <= 1'b0;
        end else begin
            r_prev_push <= w_push;
            if (w_gnt_bad) r_gnt_err <= 1'b1;
        end
    end

    assign gnt_err = r_gnt_err;
`endif

endmodule

// File: tb/tb_rr_req_queue.sv
// Directed bench for rr_req_queue with a queue-based reference model checked every cycle.
// Build with RRQ_ERR_CHECK_EN defined to also check the sticky gnt_err output.
module tb_rr_req_queue;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_data;
  logic [3:0]  REQ;
  logic [3:0]  GNT;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
`ifdef RRQ_ERR_CHECK_EN
  logic        gnt_err;
`endif

  rr_req_queue #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .REQ       (REQ),
    .GNT       (GNT),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
`ifdef RRQ_ERR_CHECK_EN
    ,
    .gnt_err   (gnt_err)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / check helper ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mq [4][$];
  logic       mv    = 1'b0;
  logic [7:0] md    = '0;
  logic [1:0] mid   = '0;
  logic [3:0] mprev = '0;
  logic       merr  = 1'b0;
  logic [3:0] m_push;
  int         m_ones;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      mv = 1'b0; md = '0; mid = '0; mprev = '0; merr = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) m_push[i] = in_valid[i] && (mq[i].size() < DEPTH);
      m_ones = $countones(GNT);
      if (m_ones > 1) merr = 1'b1;
      for (int i = 0; i < 4; i++)
        if (GNT[i] && mq[i].size() == 0 && !mprev[i]) merr = 1'b1;
      if (!mv || out_ready) begin
        mv = 1'b0;
        if (m_ones == 1)
          for (int i = 0; i < 4; i++)
            if (GNT[i] && mq[i].size() != 0) begin
              md  = mq[i].pop_front();
              mid = i[1:0];
              mv  = 1'b1;
            end
      end
      for (int i = 0; i < 4; i++)
        if (m_push[i]) mq[i].push_back(in_data[i*8 +: 8]);
      mprev = m_push;
    end
  end

  // ---------------- compare process ----------------
  logic [3:0] exp_req;
  logic [3:0] exp_rdy;

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 4; i++) begin
        exp_req[i] = (mq[i].size() != 0);
        exp_rdy[i] = (mq[i].size() < DEPTH);
      end
      chk("m_req", REQ, exp_req);
      chk("m_in_ready", in_ready, exp_rdy);
      chk("m_out_valid", out_valid, mv);
      chk("m_out_data", out_data, md);
      chk("m_out_id", out_id, mid);
`ifdef RRQ_ERR_CHECK_EN
      chk("m_gnt_err", gnt_err, merr);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push1(input int c, input logic [7:0] d);
    in_valid = 4'b0001 << c;
    in_data  = 32'(d) << (8 * c);
    tick();
    in_valid = 4'b0000;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b0;
    in_valid  = 4'b1111;
    in_data   = 32'h0;
    GNT       = 4'b0000;
    out_ready = 1'b0;
    #1 cmp_en = 1'b1;

    // reset with pushes held high
    repeat (2) @(negedge clk);
    chk("rst_req", REQ, 4'b0000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 4'b1111);
    chk("rst_out_data", out_data, 8'h00);

    in_valid = 4'b0000;
    rst      = 1'b1;
    @(negedge clk);
    in_valid = 4'b1111;
    in_data  = 32'h44332211;
    tick();
    in_valid = 4'b0000;
    chk("req_all", REQ, 4'b1111);

    // one grant per client
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      GNT = 4'b0001 << i;
      tick();
      chk("drain_valid", out_valid, 1'b1);
      chk("drain_id", out_id, i[1:0]);
      chk("drain_data", out_data, 8'(8'h11 * (i + 1)));
    end
    GNT = 4'b0000;
    tick();
    chk("drain_idle", out_valid, 1'b0);
    chk("drain_req", REQ, 4'b0000);

    // single client ordering
    push1(3, 8'h11);
    push1(3, 8'h22);
    push1(3, 8'h33);
    GNT = 4'b1000;
    tick(); chk("c3_d0", out_data, 8'h11); chk("c3_id", out_id, 2'd3);
    tick(); chk("c3_d1", out_data, 8'h22);
    tick(); chk("c3_d2", out_data, 8'h33); chk("c3_req_fall", REQ[3], 1'b0);
    GNT = 4'b0000;
    tick();

    // full FIFO
    in_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      in_data = 32'(8'hA0 + k) << 8;
      tick();
      if (k == 3) chk("full_rdy", in_ready[1], 1'b0);
    end
    in_valid = 4'b0000;
    GNT = 4'b0010;
    tick();
    chk("full_pop", out_data, 8'hA0);
    chk("full_rdy_back", in_ready[1], 1'b1);

    // backpressure
    out_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_data", out_data, 8'hA0);
      chk("bp_req", REQ[1], 1'b1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release", out_data, 8'hA1);
    GNT = 4'b0000;
    tick();
    chk("bp_drain", out_valid, 1'b0);

    // ignored grants
    push1(2, 8'h5A);
    GNT = 4'b0110;
    tick();
    chk("multi_gnt_nopop", out_valid, 1'b0);
    chk("multi_gnt_req", REQ[2], 1'b1);
`ifdef RRQ_ERR_CHECK_EN
    chk("gnt_err_set", gnt_err, 1'b1);
`endif
    GNT = 4'b0001;
    tick();
    chk("empty_gnt_nopop", out_valid, 1'b0);
    GNT = 4'b0100;
    tick();
    chk("legal_gnt_data", out_data, 8'h5A);
    chk("legal_gnt_id", out_id, 2'd2);

    // push and pop on the same FIFO
    in_valid = 4'b0010;
    in_data  = 32'h0000B000;
    GNT      = 4'b0010;
    tick();
    in_valid = 4'b0000;
    chk("pp_data", out_data, 8'hA2);
    tick(); chk("pp_next", out_data, 8'hA3);
    tick(); chk("pp_pushed", out_data, 8'hB0);
    tick(); chk("pp_empty", REQ[1], 1'b0);
    GNT = 4'b0000;
    tick();

    // rotating grants with a stall cycle
    in_valid = 4'b1111;
    in_data  = 32'hC3C2C1C0;
    tick();
    in_valid = 4'b0000;
    for (int j = 0; j < 6; j++) begin
      GNT       = 4'b0001 << (j % 4);
      out_ready = (j != 1);
      tick();
    end
    chk("rot_last", out_data, 8'hC1);
    chk("rot_req", REQ, 4'b0000);
    GNT = 4'b0000;
    out_ready = 1'b1;
    tick();

    // reset mid-transfer
    push1(0, 8'hD0);
    push1(0, 8'hD1);
    GNT       = 4'b0001;
    out_ready = 1'b0;
    tick();
    chk("mid_valid", out_valid, 1'b1);
`ifdef RRQ_ERR_CHECK_EN
    chk("gnt_err_sticky", gnt_err, 1'b1);
`endif
    #2 rst = 1'b0;
    #1;
    chk("async_valid", out_valid, 1'b0);
    chk("async_req", REQ, 4'b0000);
    chk("async_rdy", in_ready, 4'b1111);
`ifdef RRQ_ERR_CHECK_EN
    chk("gnt_err_clr", gnt_err, 1'b0);
`endif
    @(negedge clk);
    GNT = 4'b0000;
    rst = 1'b1;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
